vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Generates the VGA horizontal/vertical sync timing and the pixel coordinates that the sprite and frame-rendering logic consume. It sits at the display end of the video path, driven by the system clock. It supplies `h_sync`/`v_sync` to the monitor and to downstream line counters, plus the `h_pos`/`v_pos`/`video_on` qualifiers to the pixel pipeline. The default timing is 640x480 @ 60 Hz from a 50 MHz clock, using a divide-by-2 pixel enable.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (≥1).
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch (pixels).
- `H_SYNC`, 96: horizontal sync width (pixels).
- `H_BP`, 48: horizontal back porch (pixels).
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch (lines).
- `V_SYNC`, 2: vertical sync width (lines).
- `V_BP`, 33: vertical back porch (lines).
- `clk` in 1: system clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pix_en` out 1: one-`clk` strobe per pixel period.
- `h_sync` out 1: horizontal sync, active low.
- `v_sync` out 1: vertical sync, active low.
- `h_pos` out 10: current pixel column, 0..H_TOTAL-1.
- `v_pos` out 10: current line, 0..V_TOTAL-1.
- `video_on` out 1: high iff `h_pos` < H_ACTIVE and `v_pos` < V_ACTIVE.
- `frame_start` out 1: one-`clk` pulse when (0,0) begins.

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1, then wraps.
  - `pix_en` = (`div_cnt` == CLK_DIV-1), registered.
  - With CLK_DIV=1, `pix_en` is constantly 1 after reset.
- Horizontal counter:
  - Advances only on `pix_en`.
  - At H_TOTAL-1 it wraps to 0 and asserts an internal `line_wrap`.
- Vertical counter:
  - Advances only on `line_wrap`.
  - At V_TOTAL-1 it wraps to 0.
- Sync decode:
  - `h_sync`=0 iff `h_pos` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
  - `v_sync`=0 iff `v_pos` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
  - `h_sync` has exactly one rising edge per line, at `h_pos` 752, and none elsewhere.
  - `v_sync` has exactly one rising edge per frame, at `v_pos` 492.
- `h_sync`, `v_sync`, `video_on` and `frame_start` are registered. They are decoded from next-state counter values, so they always agree with `h_pos`/`v_pos` in the same cycle, with no skew.
- Reset values (all applied asynchronously):
  - `div_cnt`=0, `pix_en`=0.
  - `h_pos`=0, `v_pos`=0.
  - `h_sync`=1, `v_sync`=1.
  - `video_on`=1 (consistent with position (0,0)).
  - `frame_start`=0.
- Reset mid-frame: all outputs take their reset values in the same cycle `rst` rises. No partial line or frame is completed. The first post-reset frame does not pulse `frame_start`.

## Timing
- Each position holds for CLK_DIV clocks.
  - Line = H_TOTAL×CLK_DIV clk (1600).
  - Frame = V_TOTAL×H_TOTAL×CLK_DIV clk (840000).
- Counter updates occur on the `clk` edge where `pix_en` is 1.
- Wrap (799, 524)→(0,0):
  - Both counters change on the same edge.
  - `frame_start` is high for exactly that one `clk`.
- Wrap (799, n)→(0, n+1): `v_pos` and `h_pos` change on the same edge.
- Latency from `rst` deassert to the first `pix_en` is CLK_DIV clk.
- Outputs are glitch-free, since all are driven directly from flops.

## Structure
- Package `vga_timing_pkg`:
  - 640x480@60 default constants.
  - Derived H_TOTAL/V_TOTAL.
  - Position width (10).
- Sub-module `sync_axis_counter`:
  - Parameterized by ACTIVE/FP/SYNC/BP.
  - Inputs: `clk`, `rst`, `en`.
  - Outputs: `pos`, `wrap`, `sync_n`, `active`.
  - Instantiated twice: horizontal instance enabled by `pix_en`, vertical instance enabled by the horizontal `wrap`.
- The top level holds the divider, the `video_on` AND, and `frame_start`.

## Test plan
- Reset: assert `rst` at `h_pos`=300, `v_pos`=200 (between clock edges) → same cycle: `h_pos`=0, `v_pos`=0, `h_sync`=1, `v_sync`=1, `video_on`=1, `frame_start`=0.
- Divider: CLK_DIV=2 → `pix_en` alternates 0,1; `h_pos` increments every 2 clk; one line takes 1600 clk.
- Horizontal sync: per line, `h_sync` is low for exactly 192 clk, falling when `h_pos`=656 and rising when `h_pos`=752.
- Vertical sync: `v_sync` is low for lines 490–491 only (3200 clk); `v_pos` wraps 524→0.
- Frame: `frame_start` pulses once per 840000 clk, coincident with (0,0). `video_on` is high for exactly 614400 clk per frame (307200 pixels).
- Wrap corners:
  - (799, 479)→(0, 480): `video_on` stays 0 in this transition.
  - (639, 0)→(640, 0): `video_on` falls on the same edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the VGA sync generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned POS_W = 10;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: position counter with wrap strobe, active-low sync and active-region flag.
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             sync_n,
    output logic             active
);

    localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam pos_t        LAST       = POS_W'(TOTAL - 1);
    localparam pos_t        SYNC_FIRST = POS_W'(ACTIVE + FP);
    localparam pos_t        SYNC_LAST  = POS_W'(ACTIVE + FP + SYNC - 1);
    localparam pos_t        ACT_END    = POS_W'(ACTIVE);

    pos_t pos_next;

    // wrap is combinational so the next axis advances on the same edge;
    // active describes pos_next, letting the parent register it in step with pos.
    always_comb begin
        wrap     = en && (pos == LAST);
        pos_next = pos;
        if (en) begin
            pos_next = wrap ? '0 : pos + 1'b1;
        end
        active   = (pos_next < ACT_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos    <= '0;
            sync_n <= 1'b1;
        end else begin
            pos    <= pos_next;
            sync_n <= !((pos_next >= SYNC_FIRST) && (pos_next <= SYNC_LAST));
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel-enable divider plus horizontal/vertical axis counters,
// with all outputs registered so they line up with h_pos/v_pos.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic             h_sync,
    output logic             v_sync,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             video_on,
    output logic             frame_start
);

    localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             line_wrap;
    logic             frame_wrap;
    logic             h_active;
    logic             v_active;

    sync_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en),
        .pos    (h_pos),
        .wrap   (line_wrap),
        .sync_n (h_sync),
        .active (h_active)
    );

    sync_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (line_wrap),
        .pos    (v_pos),
        .wrap   (frame_wrap),
        .sync_n (v_sync),
        .active (v_active)
    );

    // frame_wrap implies line_wrap, so it marks the (last,last)->(0,0) edge exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            pix_en      <= (div_cnt == DIV_LAST);
            video_on    <= h_active & v_active;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced timing so several whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int unsigned D   = 2;
    localparam int unsigned HA  = 16;
    localparam int unsigned HFP = 4;
    localparam int unsigned HS  = 6;
    localparam int unsigned HBP = 5;
    localparam int unsigned VA  = 10;
    localparam int unsigned VFP = 2;
    localparam int unsigned VS  = 3;
    localparam int unsigned VBP = 4;
    localparam int unsigned HT    = HA + HFP + HS + HBP;
    localparam int unsigned VT    = VA + VFP + VS + VBP;
    localparam int unsigned LINE  = HT * D;
    localparam int unsigned FRAME = HT * VT * D;

    typedef struct packed {
        logic       pe;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic [9:0] h;
        logic [9:0] v;
    } obs_t;

    localparam obs_t RESET_OBS = '{pe: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b1, fs: 1'b0, h: 10'd0, v: 10'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en, h_sync, v_sync, video_on, frame_start;
    logic [9:0] h_pos, v_pos;

    int unsigned k;
    int          tests = 0;
    int          fails = 0;

    vga_sync_gen #(
        .CLK_DIV  (D),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .video_on    (video_on),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was last released.
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Expected outputs after k edges: pixel p = floor((k-1)/D) advanced, laid out row-major.
    function automatic obs_t model(input int unsigned kk);
        obs_t        o;
        int unsigned p, lin, h, v;
        p   = (kk == 0) ? 0 : (kk - 1) / D;
        lin = p % (HT * VT);
        h   = lin % HT;
        v   = lin / HT;
        o.pe  = (kk >= 1) && (kk % D == 0);
        o.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
        o.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
        o.von = (h < HA) && (v < VA);
        o.fs  = (kk >= 2) && ((kk - 1) % D == 0) && (lin == 0);
        o.h   = 10'(h);
        o.v   = 10'(v);
        return o;
    endfunction

    function automatic obs_t cur();
        return {pix_en, h_sync, v_sync, video_on, frame_start, h_pos, v_pos};
    endfunction

    task automatic wait_pos(input int unsigned h, input int unsigned v, input int unsigned budget,
                            output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (h_pos == 10'(h) && v_pos == 10'(v)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (cur() !== RESET_OBS) begin
            fails++;
            $display("FAIL reset_hold: got %h want %h", cur(), RESET_OBS);
        end
        rst = 1'b0;
        wait_pos(HT / 2, VT / 2, FRAME + 10, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_reach_mid: position (%0d,%0d) not reached", HT / 2, VT / 2);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (cur() !== RESET_OBS) begin
            fails++;
            $display("FAIL reset_midframe: got %h want %h", cur(), RESET_OBS);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divider();
        obs_t exp_o;
        for (int unsigned i = 0; i < 6 * D; i++) begin
            if (i > 0) @(negedge clk);
            exp_o = model(k);
            tests++;
            if (cur() !== exp_o) begin
                fails++;
                $display("FAIL divider k=%0d: got %h want %h", k, cur(), exp_o);
            end
        end
    endtask

    task automatic test_random_walk();
        obs_t        exp_o;
        int unsigned n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(100, 1500);
            for (int unsigned i = 0; i < n; i++) begin
                @(negedge clk);
                exp_o = model(k);
                tests++;
                if (cur() !== exp_o) begin
                    fails++;
                    $display("FAIL walk k=%0d: got %h want %h", k, cur(), exp_o);
                end
            end
            #($urandom_range(1, 3)) rst = 1'b1;
            #1;
            tests++;
            if (cur() !== RESET_OBS) begin
                fails++;
                $display("FAIL walk_reset: got %h want %h", cur(), RESET_OBS);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic test_hsync();
        bit ok;
        int unsigned lows, rises, falls;
        logic prev;
        wait_pos(0, $urandom_range(0, VT - 1), FRAME + 10, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL hsync_start: line start not reached");
            return;
        end
        lows = 0; rises = 0; falls = 0; prev = h_sync;
        for (int unsigned i = 0; i < LINE; i++) begin
            if (i > 0) @(negedge clk);
            if (!h_sync) lows++;
            if (i > 0 && !prev && h_sync) begin
                rises++;
                tests++;
                if (h_pos != 10'(HA + HFP + HS)) begin
                    fails++;
                    $display("FAIL hsync_rise_pos: got %0d want %0d", h_pos, HA + HFP + HS);
                end
            end
            if (i > 0 && prev && !h_sync) begin
                falls++;
                tests++;
                if (h_pos != 10'(HA + HFP)) begin
                    fails++;
                    $display("FAIL hsync_fall_pos: got %0d want %0d", h_pos, HA + HFP);
                end
            end
            prev = h_sync;
        end
        tests++;
        if (lows != HS * D || rises != 1 || falls != 1) begin
            fails++;
            $display("FAIL hsync_line: low=%0d rises=%0d falls=%0d want %0d/1/1", lows, rises, falls, HS * D);
        end
    endtask

    task automatic test_frame();
        bit ok;
        int unsigned fs_cnt, von_cnt, vs_low, vs_rise, vmax;
        logic prev;
        ok = 1'b0;
        for (int unsigned i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || h_pos !== 10'd0 || v_pos !== 10'd0) begin
            fails++;
            $display("FAIL frame_start_pos: seen=%0d at (%0d,%0d) want (0,0)", ok, h_pos, v_pos);
            return;
        end
        fs_cnt = 0; von_cnt = 0; vs_low = 0; vs_rise = 0; vmax = 0; prev = v_sync;
        for (int unsigned i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (frame_start) fs_cnt++;
            if (video_on) von_cnt++;
            if (!v_sync) vs_low++;
            if (v_pos > vmax) vmax = v_pos;
            if (i > 0 && !prev && v_sync) begin
                vs_rise++;
                tests++;
                if (v_pos != 10'(VA + VFP + VS) || h_pos != 10'd0) begin
                    fails++;
                    $display("FAIL vsync_rise_pos: got (%0d,%0d) want (0,%0d)", h_pos, v_pos, VA + VFP + VS);
                end
            end
            prev = v_sync;
        end
        tests++;
        if (fs_cnt != 1 || von_cnt != HA * VA * D) begin
            fails++;
            $display("FAIL frame_counts: fs=%0d video_on=%0d want 1/%0d", fs_cnt, von_cnt, HA * VA * D);
        end
        tests++;
        if (vs_low != VS * HT * D || vs_rise != 1 || vmax != VT - 1) begin
            fails++;
            $display("FAIL vsync_frame: low=%0d rises=%0d vmax=%0d want %0d/1/%0d",
                     vs_low, vs_rise, vmax, VS * HT * D, VT - 1);
        end
    endtask

    task automatic test_corners();
        bit ok;
        // (HT-1, VA-1) -> (0, VA): blanked on both sides of the wrap.
        wait_pos(HT - 1, VA - 1, FRAME + 10, ok);
        tests++;
        if (!ok || video_on !== 1'b0) begin
            fails++;
            $display("FAIL corner_last_line: seen=%0d video_on=%b want 0", ok, video_on);
        end
        wait_pos(0, VA, D + 2, ok);
        tests++;
        if (!ok || video_on !== 1'b0) begin
            fails++;
            $display("FAIL corner_first_blank: seen=%0d video_on=%b want 0", ok, video_on);
        end
        // (HA-1, 0) -> (HA, 0): video_on falls with the column change.
        wait_pos(HA - 1, 0, FRAME + 10, ok);
        tests++;
        if (!ok || video_on !== 1'b1) begin
            fails++;
            $display("FAIL corner_last_active: seen=%0d video_on=%b want 1", ok, video_on);
        end
        wait_pos(HA, 0, D + 2, ok);
        tests++;
        if (!ok || video_on !== 1'b0) begin
            fails++;
            $display("FAIL corner_active_end: seen=%0d video_on=%b want 0", ok, video_on);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_random_walk();
        test_divider();
        test_hsync();
        test_frame();
        test_corners();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
